// File: rtl/dp_pkg.sv
// Shared lane arithmetic for the vector adder datapath: one add with
// overflow detect and optional clamping, sized at call time by a width argument.
package dp_pkg;

  localparam int MAX_WIDTH = 64;
  localparam logic [MAX_WIDTH-1:0] ALL_ONES     = '1;
  localparam logic [MAX_WIDTH-1:0] UNSIGNED_MIN = '0;

  // Saturation limits for a w-bit lane, right-aligned in a MAX_WIDTH word.
  function automatic logic [MAX_WIDTH-1:0] unsigned_max(input int unsigned w);
    return ALL_ONES >> (MAX_WIDTH - w);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] signed_max(input int unsigned w);
    return ALL_ONES >> (MAX_WIDTH - w + 1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] signed_min(input int unsigned w);
    return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (w - 1);
  endfunction

  // Returns {ovf, sum}; sum occupies the low w bits, upper bits are zero.
  function automatic logic [MAX_WIDTH:0] lane_add_sat(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input int unsigned          w,
    input logic                 is_signed,
    input logic                 saturate
  );
    logic [MAX_WIDTH:0]   raw;
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] res;
    logic [5:0]           msb_idx;
    logic [6:0]           carry_idx;
    logic                 a_msb;
    logic                 b_msb;
    logic                 r_msb;
    logic                 ovf;
    mask      = unsigned_max(w);
    msb_idx   = 6'(w - 1);
    carry_idx = 7'(w);
    raw       = {1'b0, a & mask} + {1'b0, b & mask};
    a_msb     = a[msb_idx];
    b_msb     = b[msb_idx];
    r_msb     = raw[msb_idx];
    ovf       = is_signed ? ((a_msb == b_msb) && (r_msb != a_msb)) : raw[carry_idx];
    res       = raw[MAX_WIDTH-1:0] & mask;
    if (saturate && ovf) begin
      if (!is_signed)
        res = mask;
      else
        res = a_msb ? signed_min(w) : signed_max(w);
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage of the vector adder: valid, data and flag registers
// that load together when enabled and clear on asynchronous reset.
module pipe_stage_reg #(
  parameter int DATA_WIDTH = 8,
  parameter int FLAG_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  valid_d,
  input  logic [DATA_WIDTH-1:0] data_d,
  input  logic [FLAG_WIDTH-1:0] flag_d,
  output logic                  valid_q,
  output logic [DATA_WIDTH-1:0] data_q,
  output logic [FLAG_WIDTH-1:0] flag_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      flag_q  <= '0;
    end else if (en) begin
      valid_q <= valid_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
    end
  end

endmodule

// File: rtl/pipelined_vector_adder.sv
// LANES-wide adder with per-lane overflow, optional saturation and a
// PIPE_STAGES-deep stall-as-a-whole pipeline behind a valid/ready handshake.
module pipelined_vector_adder
  import dp_pkg::*;
#(
  parameter int BIT_WIDTH   = 8,
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2,
  parameter int SIGNED      = 0,
  parameter int SATURATE    = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*BIT_WIDTH-1:0] a,
  input  logic [LANES*BIT_WIDTH-1:0] b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*BIT_WIDTH-1:0] sum,
  output logic [LANES-1:0]           ovf
);

  localparam int DW = LANES * BIT_WIDTH;

  if (PIPE_STAGES < 1 || PIPE_STAGES > 8) begin : g_bad_stages
    $error("pipelined_vector_adder: PIPE_STAGES must be in 1..8");
  end
  if (BIT_WIDTH < 1 || BIT_WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("pipelined_vector_adder: BIT_WIDTH must be in 1..64");
  end

  logic                 adv;
  logic [DW-1:0]        calc_sum;
  logic [LANES-1:0]     calc_ovf;
  logic [PIPE_STAGES:0] stg_valid;
  logic [DW-1:0]        stg_sum [PIPE_STAGES+1];
  logic [LANES-1:0]     stg_ovf [PIPE_STAGES+1];

  // The whole pipe moves or holds as one; a full output with no taker freezes everything.
  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [MAX_WIDTH:0] res;
    logic               unused_res;
    assign res = lane_add_sat(MAX_WIDTH'(a[i*BIT_WIDTH +: BIT_WIDTH]),
                              MAX_WIDTH'(b[i*BIT_WIDTH +: BIT_WIDTH]),
                              BIT_WIDTH, SIGNED != 0, SATURATE != 0);
    assign calc_sum[i*BIT_WIDTH +: BIT_WIDTH] = res[BIT_WIDTH-1:0];
    assign calc_ovf[i]                        = res[MAX_WIDTH];
    assign unused_res                         = ^res;
  end

  assign stg_valid[0] = in_valid;
  assign stg_sum[0]   = calc_sum;
  assign stg_ovf[0]   = calc_ovf;

  for (genvar s = 1; s <= PIPE_STAGES; s++) begin : g_stage
    pipe_stage_reg #(
      .DATA_WIDTH(DW),
      .FLAG_WIDTH(LANES)
    ) u_stage (
      .clk    (clk),
      .rst    (reset),
      .en     (adv),
      .valid_d(stg_valid[s-1]),
      .data_d (stg_sum[s-1]),
      .flag_d (stg_ovf[s-1]),
      .valid_q(stg_valid[s]),
      .data_q (stg_sum[s]),
      .flag_q (stg_ovf[s])
    );
  end

  assign out_valid = stg_valid[PIPE_STAGES];
  assign sum       = stg_sum[PIPE_STAGES];
  assign ovf       = stg_ovf[PIPE_STAGES];

endmodule

// File: tb/tb_pipelined_vector_adder.sv
// Self-checking bench: four adder configurations (8-bit, 2 lanes) checked
// against an integer-arithmetic reference model and a FIFO scoreboard.
module tb_pipelined_vector_adder;

  localparam int ND = 4;
  localparam int STG [ND] = '{2, 3, 1, 8};
  localparam int SG  [ND] = '{0, 0, 1, 1};
  localparam int ST  [ND] = '{0, 1, 1, 0};

  logic        clk = 1'b0;
  logic        reset;
  logic        iv  [ND];
  logic        ir  [ND];
  logic        ov  [ND];
  logic        orr [ND];
  logic [15:0] av  [ND];
  logic [15:0] bv  [ND];
  logic [15:0] sm  [ND];
  logic [1:0]  of  [ND];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    pipelined_vector_adder #(
      .BIT_WIDTH  (8),
      .LANES      (2),
      .PIPE_STAGES(STG[g]),
      .SIGNED     (SG[g]),
      .SATURATE   (ST[g])
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (iv[g]),
      .in_ready (ir[g]),
      .a        (av[g]),
      .b        (bv[g]),
      .out_valid(ov[g]),
      .out_ready(orr[g]),
      .sum      (sm[g]),
      .ovf      (of[g])
    );
  end

  // Reference: exact integer sum, range check, then clamp or wrap.
  function automatic logic [8:0] ref_lane(input logic [7:0] x, input logic [7:0] y,
                                          input int sg, input int sat);
    int xi, yi, r, lo, hi;
    bit o;
    xi = int'(x);
    yi = int'(y);
    if (sg != 0) begin
      if (xi > 127) xi -= 256;
      if (yi > 127) yi -= 256;
      lo = -128;
      hi = 127;
    end else begin
      lo = 0;
      hi = 255;
    end
    r = xi + yi;
    o = (r < lo) || (r > hi);
    if (o && sat != 0) r = (r > hi) ? hi : lo;
    return {o, r[7:0]};
  endfunction

  function automatic logic [17:0] ref_vec(input logic [15:0] x, input logic [15:0] y, input int d);
    logic [8:0] l0, l1;
    l0 = ref_lane(x[7:0], y[7:0], SG[d], ST[d]);
    l1 = ref_lane(x[15:8], y[15:8], SG[d], ST[d]);
    return {l1[8], l0[8], l1[7:0], l0[7:0]};
  endfunction

  task automatic run_one(input int d, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] es, input logic [1:0] eo, input string name);
    int lat;
    @(negedge clk);
    orr[d] = 1'b1;
    iv[d]  = 1'b1;
    av[d]  = x;
    bv[d]  = y;
    #1;
    n_tests++;
    if (ir[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s in_ready: got %b expected 1", name, ir[d]);
    end
    @(negedge clk);
    iv[d] = 1'b0;
    lat   = 1;
    #1;
    while (ov[d] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
      #1;
    end
    n_tests++;
    if (lat != STG[d]) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, STG[d]);
    end
    n_tests++;
    if (sm[d] !== es) begin
      n_fail++;
      $display("FAIL %s sum: got %h expected %h", name, sm[d], es);
    end
    n_tests++;
    if (of[d] !== eo) begin
      n_fail++;
      $display("FAIL %s ovf: got %b expected %b", name, of[d], eo);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (ov[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s single_cycle out_valid: got %b expected 0", name, ov[d]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int d = 0; d < ND; d++) begin
      iv[d]  = 1'b0;
      orr[d] = 1'b0;
      av[d]  = '0;
      bv[d]  = '0;
    end
    #3;
    for (int d = 0; d < ND; d++) begin
      n_tests++;
      if (ov[d] !== 1'b0 || sm[d] !== 16'h0 || of[d] !== 2'b00 || ir[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset dut%0d: got ov=%b sum=%h ovf=%b rdy=%b expected 0 0 0 1",
                 d, ov[d], sm[d], of[d], ir[d]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      n_tests++;
      if (ir[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL post_reset_ready dut%0d: got %b expected 1", d, ir[d]);
      end
      orr[d] = 1'b1;
    end
  endtask

  task automatic test_basic_add();
    run_one(0, 16'h0AC8, 16'h0564, 16'h0F2C, 2'b01, "basic_add");
  endtask

  task automatic test_unsigned_sat();
    run_one(1, 16'h03FA, 16'h040A, 16'h07FF, 2'b01, "unsigned_sat");
  endtask

  task automatic test_signed_sat();
    run_one(2, 16'h9C64, 16'h9C64, 16'h807F, 2'b11, "signed_sat_clamp");
    run_one(2, 16'h3232, 16'hECEC, 16'h1E1E, 2'b00, "signed_sat_noovf");
  endtask

  task automatic test_latency();
    logic [15:0] x, y;
    logic [17:0] e;
    x = 16'($urandom);
    y = 16'($urandom);
    e = ref_vec(x, y, 2);
    run_one(2, x, y, e[15:0], e[17:16], "latency_p1");
    run_one(3, 16'h017F, 16'h0101, 16'h0280, 2'b01, "latency_p8_wrap");
  endtask

  // Output not ready but pipe empty: the item must still travel to the output, then hold.
  task automatic test_fill_bubbles();
    logic [15:0] x, y, held;
    logic [17:0] e;
    int d;
    d = 1;
    x = 16'($urandom);
    y = 16'($urandom);
    e = ref_vec(x, y, d);
    @(negedge clk);
    orr[d] = 1'b0;
    iv[d]  = 1'b1;
    av[d]  = x;
    bv[d]  = y;
    for (int k = 0; k < STG[d]; k++) begin
      @(negedge clk);
      iv[d] = 1'b0;
    end
    #1;
    n_tests++;
    if (ov[d] !== 1'b1 || ir[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_bubbles arrive: got ov=%b rdy=%b expected 1 0", ov[d], ir[d]);
    end
    held = sm[d];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if (ov[d] !== 1'b1 || sm[d] !== held) begin
        n_fail++;
        $display("FAIL fill_bubbles hold: got ov=%b sum=%h expected 1 %h", ov[d], sm[d], held);
      end
    end
    n_tests++;
    if ({of[d], sm[d]} !== e) begin
      n_fail++;
      $display("FAIL fill_bubbles data: got %h expected %h", {of[d], sm[d]}, e);
    end
    @(negedge clk);
    orr[d] = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (ov[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_bubbles drain: got %b expected 0", ov[d]);
    end
  endtask

  // mode 0: out_ready high; mode 1: back-to-back inputs, out_ready 1,0,0,1; mode 2: random both sides.
  task automatic test_stream(input int d, input int n, input int mode, input string name);
    logic [17:0] q[$];
    logic [17:0] e;
    logic [15:0] psum;
    logic [1:0]  pof;
    int sent, got, cyc;
    bit pend, pstall;
    sent = 0; got = 0; cyc = 0; pend = 0; pstall = 0;
    psum = '0; pof = '0;
    while (got < n && cyc < n * 10 + 60) begin
      @(negedge clk);
      case (mode)
        0:       orr[d] = 1'b1;
        1:       orr[d] = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: orr[d] = 1'($urandom_range(0, 1));
      endcase
      cyc++;
      if (!pend) begin
        iv[d] = (sent < n) && (mode != 2 || $urandom_range(0, 3) != 0);
        av[d] = 16'($urandom);
        bv[d] = 16'($urandom);
      end
      #1;
      n_tests++;
      if (ir[d] !== (orr[d] || !ov[d])) begin
        n_fail++;
        $display("FAIL %s in_ready: got %b expected %b", name, ir[d], orr[d] || !ov[d]);
      end
      if (pstall) begin
        n_tests++;
        if (ov[d] !== 1'b1 || sm[d] !== psum || of[d] !== pof) begin
          n_fail++;
          $display("FAIL %s stall_stable: got ov=%b %b_%h expected 1 %b_%h",
                   name, ov[d], of[d], sm[d], pof, psum);
        end
      end
      if (ov[d] === 1'b1 && orr[d]) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_output: got %h expected none", name, {of[d], sm[d]});
        end else begin
          e = q.pop_front();
          if ({of[d], sm[d]} !== e) begin
            n_fail++;
            $display("FAIL %s data item %0d: got %h expected %h", name, got, {of[d], sm[d]}, e);
          end
        end
        got++;
      end
      if (iv[d] && ir[d] === 1'b1) begin
        q.push_back(ref_vec(av[d], bv[d], d));
        sent++;
        pend = 0;
      end else begin
        pend = iv[d];
      end
      pstall = (ov[d] === 1'b1) && !orr[d];
      psum   = sm[d];
      pof    = of[d];
    end
    @(negedge clk);
    iv[d]  = 1'b0;
    orr[d] = 1'b1;
    n_tests++;
    if (got != n || q.size() != 0) begin
      n_fail++;
      $display("FAIL %s count: got %0d outputs (%0d pending) expected %0d", name, got, q.size(), n);
    end
    for (int k = 0; k <= STG[d]; k++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if (ov[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s duplicate: got out_valid=%b expected 0", name, ov[d]);
      end
    end
  endtask

  task automatic test_backpressure();
    test_stream(1, 10, 1, "backpressure");
  endtask

  task automatic test_back_to_back();
    for (int d = 0; d < ND; d++) test_stream(d, 30, 0, $sformatf("back_to_back_dut%0d", d));
  endtask

  task automatic test_random_traffic();
    for (int d = 0; d < ND; d++) test_stream(d, 40, 2, $sformatf("random_dut%0d", d));
  endtask

  task automatic test_reset_midstream();
    logic [15:0] x, y;
    logic [17:0] e;
    int d;
    d = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      orr[d] = 1'b1;
      iv[d]  = 1'b1;
      av[d]  = 16'($urandom);
      bv[d]  = 16'($urandom);
    end
    @(negedge clk);
    iv[d]  = 1'b0;
    orr[d] = 1'b0;
    #1;
    n_tests++;
    if (ov[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midstream in_flight: got %b expected 1", ov[d]);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (ov[d] !== 1'b0 || sm[d] !== 16'h0 || of[d] !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_midstream clear: got ov=%b sum=%h ovf=%b expected 0 0 0",
               ov[d], sm[d], of[d]);
    end
    @(negedge clk);
    reset  = 1'b0;
    orr[d] = 1'b1;
    #1;
    n_tests++;
    if (ir[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midstream ready: got %b expected 1", ir[d]);
    end
    x = 16'($urandom);
    y = 16'($urandom);
    e = ref_vec(x, y, d);
    run_one(d, x, y, e[15:0], e[17:16], "reset_midstream_next");
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_unsigned_sat();
    test_signed_sat();
    test_latency();
    test_fill_bubbles();
    test_backpressure();
    test_back_to_back();
    test_random_traffic();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_vector_adder.md
Name: pipelined_vector_adder

Overview:
Parametrised successor to the team's single-cycle registered adder, used in the matrix-multiply datapath for partial-sum reduction. Adds LANES independent BIT_WIDTH operand pairs per transfer. The block has a configurable pipeline depth, selectable signed/unsigned and wrap/saturate arithmetic, per-lane overflow flags, and a valid/ready handshake with backpressure.

Parameters:
BIT_WIDTH, 8, width of each lane operand and result
LANES, 4, number of parallel adder lanes
PIPE_STAGES, 2, register stages from input to output; legal values are 1 to 8
SIGNED, 0, 1 selects two's-complement operands, 0 selects unsigned operands
SATURATE, 0, 1 clamps results on overflow, 0 wraps results modulo 2^BIT_WIDTH

Ports:
clk  input  1  single clock; all logic is on the rising edge
reset  input  1  asynchronous, active-high; clears all pipeline state
in_valid  input  1  input transfer request
in_ready  output  1  block can accept an input this cycle
a  input  LANES*BIT_WIDTH  packed operand A; lane i occupies bits [i*BIT_WIDTH +: BIT_WIDTH]
b  input  LANES*BIT_WIDTH  packed operand B, same packing as a
out_valid  output  1  result present on the outputs
out_ready  input  1  downstream accepts the result
sum  output  LANES*BIT_WIDTH  packed per-lane result
ovf  output  LANES  per-lane overflow flag, aligned with sum

Behaviour:
- Reset (asynchronous, active-high):
  - All stage valid bits clear to 0.
  - sum and ovf clear to 0.
  - out_valid = 0.
  - in_ready = 1 in the first cycle after reset deasserts.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Global advance enable: adv = out_ready || !out_valid.
  - in_ready = adv, combinational. There is no combinational path from in_valid to in_ready.
- Pipeline operation:
  - When adv = 1, every stage loads from the stage before it.
  - Stage 1 loads valid = in_valid, plus the computed sum and ovf.
  - When adv = 0, every stage holds its contents.
  - Bubbles are not collapsed while stalled.
- Latency:
  - An accepted input appears at out_valid exactly PIPE_STAGES cycles later, provided out_ready stays high.
  - Throughput is one transfer per cycle.
- Stall rules:
  - While out_valid = 1 and out_ready = 0, sum and ovf stay stable.
  - No data is lost or duplicated.
- Arithmetic is computed combinationally before stage 1; stages 2 to PIPE_STAGES are delay only.
  - Form the full BIT_WIDTH+1 result.
  - Unsigned: ovf = carry out of the MSB.
  - Signed: ovf = (a_msb == b_msb) && (raw_msb != a_msb).
  - SATURATE = 0: sum = low BIT_WIDTH bits of the result; ovf is still reported.
  - SATURATE = 1, unsigned overflow: sum = all ones.
  - SATURATE = 1, signed positive overflow: sum = 0111...1.
  - SATURATE = 1, signed negative overflow: sum = 1000...0.
- Lanes are fully independent; overflow in one lane does not affect any other lane.
- Boundary conditions:
  - With out_valid = 0 and out_ready = 0, adv = 1, so the pipeline fills through the bubbles.
  - With every stage full and out_ready = 0, in_ready = 0.
  - A simultaneous input and output transfer in the same cycle is legal and sustains full throughput.
  - Reset asserted mid-stream discards all in-flight data; out_valid drops to 0 asynchronously.
  - With PIPE_STAGES = 1, the block matches the legacy single-cycle adder timing and adds the handshake and flags.
- Elaboration check: PIPE_STAGES outside the range 1 to 8 raises an elaboration-time error.

Decomposition:
- Shared package dp_pkg holds:
  - function lane_add_sat, taking (a, b, signed, saturate) and returning {ovf, sum}.
  - Localparams for the saturation constants (max and min unsigned and signed values).
- Sub-module pipe_stage_reg holds one stage: valid, data and ovf registers with an enable input and asynchronous reset.
  - The top module instantiates it PIPE_STAGES times in a generate loop.
  - The top module holds the lane arithmetic and the adv logic.

Test Plan:
Unless stated otherwise, BIT_WIDTH = 8 and LANES = 2.
- Basic add (SIGNED = 0, SATURATE = 0, PIPE_STAGES = 2). Input a = {8'd10, 8'd200}, b = {8'd5, 8'd100}, out_ready = 1. Expect after 2 cycles: sum = {8'd15, 8'd44}, ovf = 2'b01, out_valid for 1 cycle.
- Unsigned saturate (SATURATE = 1). Lane 0: 250 + 10; lane 1: 3 + 4. Expect sum = {8'd7, 8'd255}, ovf = 2'b01.
- Signed saturate (SIGNED = 1, SATURATE = 1).
  - Lane 0: 100 + 100; expect 127 with ovf = 1.
  - Lane 1: -100 + -100; expect -128 (8'h80) with ovf = 1.
  - Then 50 + (-20) in both lanes; expect 30 with ovf = 0.
- Backpressure (PIPE_STAGES = 3). Stream 10 back-to-back inputs with out_ready toggling 1,0,0,1. Expect:
  - All 10 results in order, none lost or duplicated.
  - sum stable while stalled.
  - in_ready = 0 whenever the pipe is full and out_ready = 0.
- Reset mid-stream. Assert reset asynchronously between clock edges with 3 items in flight. Expect:
  - out_valid = 0 immediately.
  - sum = 0 and ovf = 0.
  - in_ready = 1 after release.
  - The next input completes with normal latency.
- Latency sweep (PIPE_STAGES = 1 and 8). Apply a single transfer. Expect out_valid exactly 1 or 8 cycles after acceptance, respectively.
